// File: rtl/fifo_piso_serializer.sv
// fifo_piso_serializer
// Pops one word at a time from the asynchronous FIFO's read port and shifts
// it out one bit per tick_i strobe. The serial line carries valid and
// last-bit qualifiers.
// Optional feature: define FIFO_PISO_PARITY_EN to append an even-parity bit
// after the data bits of every frame.
module fifo_piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  input  logic             tick_i,
  output logic             sdata_o,
  output logic             svalid_o,
  output logic             slast_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 2);

`ifdef FIFO_PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
  localparam int N         = WIDTH + 1;
`else
  localparam bit PARITY_EN = 1'b0;
  localparam int N         = WIDTH;
`endif

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] PAR_IDX  = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;

  logic             rd_en_d;
  logic             sdata_d;
  logic             svalid_d;
  logic             slast_d;
  logic             busy_d;

  // Next-state and datapath; outputs are derived from the next state so that
  // every output can be registered without adding a cycle of lag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty_i) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d = fifo_rdata_i;
        par_d   = ^fifo_rdata_i;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (tick_i) begin
          if (cnt_q == LAST_IDX) begin
            state_d = fifo_empty_i ? IDLE : FETCH;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_en_d  = (state_d == FETCH);
    busy_d   = (state_d != IDLE);
    svalid_d = (state_d == SHIFT);
    slast_d  = svalid_d && (cnt_d == LAST_IDX);

    if (!svalid_d) begin
      sdata_d = 1'b1;
    end else if (PARITY_EN && (cnt_d == PAR_IDX)) begin
      sdata_d = par_d;
    end else begin
      sdata_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    end
  end

  // State, datapath and output registers; reset drops any word already popped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      fifo_rd_en_o <= 1'b0;
      sdata_o      <= 1'b1;
      svalid_o     <= 1'b0;
      slast_o      <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      fifo_rd_en_o <= rd_en_d;
      sdata_o      <= sdata_d;
      svalid_o     <= svalid_d;
      slast_o      <= slast_d;
      busy_o       <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_piso_serializer.sv
// tb_fifo_piso_serializer
// Two serializers (LSB-first and MSB-first) share one behavioural FIFO.
// Words pushed into the FIFO also push their expected serial bits into
// per-instance queues; a monitor pops and compares as bits appear.
module tb_fifo_piso_serializer;

  localparam int WIDTH = 8;

`ifdef FIFO_PISO_PARITY_EN
  localparam int FRAME_N = WIDTH + 1;
`else
  localparam int FRAME_N = WIDTH;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_rdata_i;
  logic             tick_i;
  logic [1:0]       rd_en;
  logic [1:0]       sdata;
  logic [1:0]       svalid;
  logic [1:0]       slast;
  logic [1:0]       busy;

  exp_t             exp0[$];
  exp_t             exp1[$];
  logic [WIDTH-1:0] fifoq[$];

  int checks       = 0;
  int failures     = 0;
  int words_pushed = 0;
  int rd_cnt[2]    = '{0, 0};
  int tick_mode    = 0;

  always #5 clk_i = ~clk_i;

  fifo_piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_en_o (rd_en[0]),
    .tick_i       (tick_i),
    .sdata_o      (sdata[0]),
    .svalid_o     (svalid[0]),
    .slast_o      (slast[0]),
    .busy_o       (busy[0])
  );

  fifo_piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_en_o (rd_en[1]),
    .tick_i       (tick_i),
    .sdata_o      (sdata[1]),
    .svalid_o     (svalid[1]),
    .slast_o      (slast[1]),
    .busy_o       (busy[1])
  );

  // Single comparison point: counts every check and reports any failure.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Put a word into the FIFO and queue the serial bits each instance owes.
  task automatic applyStimulus(input logic [WIDTH-1:0] w);
    exp_t e;
    fifoq.push_back(w);
    words_pushed++;
    for (int i = 0; i < WIDTH; i++) begin
      e.last = (i == FRAME_N - 1);
      e.b    = w[i];
      exp0.push_back(e);
      e.b    = w[WIDTH-1-i];
      exp1.push_back(e);
    end
`ifdef FIFO_PISO_PARITY_EN
    e.last = 1'b1;
    e.b    = ^w;
    exp0.push_back(e);
    exp1.push_back(e);
`endif
  endtask

  // Wait until everything queued has been serialized and both blocks are idle.
  task automatic waitIdle(input int budget);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk_i);
      #1;
      n++;
      done = (exp0.size() == 0) && (exp1.size() == 0) &&
             (fifoq.size() == 0) && (busy == 2'b00);
    end
    checkOutput("drain_complete", {31'd0, done}, 32'd1);
  endtask

  // Tick generator: 0 = off, 1 = every clock, 2 = every 4th clock, 3 = random.
  initial begin : tick_gen
    int tc;
    tc     = 0;
    tick_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      tc++;
      case (tick_mode)
        1:       tick_i = 1'b1;
        2:       tick_i = ((tc % 4) == 3);
        3:       tick_i = ($urandom_range(0, 2) != 0);
        default: tick_i = 1'b0;
      endcase
    end
  end

  // FIFO responder and scoreboard monitor, both on the falling edge.
  initial begin : monitor
    exp_t cur[2];
    logic prev_v[2];
    logic prev_t;
    exp_t e;
    prev_v[0]    = 1'b0;
    prev_v[1]    = 1'b0;
    prev_t       = 1'b0;
    cur[0]       = '0;
    cur[1]       = '0;
    fifo_empty_i = 1'b1;
    fifo_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_n_i) begin
        for (int d = 0; d < 2; d++) begin
          if (svalid[d]) begin
            if (!prev_v[d] || prev_t) begin
              if ((d == 0 ? exp0.size() : exp1.size()) == 0) begin
                checkOutput("unexpected_bit", 32'd1, 32'd0);
              end else begin
                e      = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                cur[d] = e;
              end
            end
            checkOutput(d == 0 ? "sdata_lsb" : "sdata_msb", {31'd0, sdata[d]}, {31'd0, cur[d].b});
            checkOutput(d == 0 ? "slast_lsb" : "slast_msb", {31'd0, slast[d]}, {31'd0, cur[d].last});
            checkOutput("busy_in_shift", {31'd0, busy[d]}, 32'd1);
          end else begin
            checkOutput("idle_sdata", {31'd0, sdata[d]}, 32'd1);
            checkOutput("idle_slast", {31'd0, slast[d]}, 32'd0);
          end
          prev_v[d] = svalid[d];
          if (rd_en[d]) begin
            rd_cnt[d]++;
            checkOutput("read_while_empty", {31'd0, (fifoq.size() != 0)}, 32'd1);
          end
        end
        if (rd_en[0] && fifoq.size() != 0) begin
          fifo_rdata_i = fifoq.pop_front();
        end
      end else begin
        prev_v[0] = 1'b0;
        prev_v[1] = 1'b0;
      end
      prev_t       = tick_i;
      fifo_empty_i = (fifoq.size() == 0);
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized run.
  initial begin : main
    int cycles;
    int r0;
    int gap;
    int n;
    rst_n_i   = 1'b0;
    tick_mode = 1;

    // Reset held while the FIFO holds data: nothing may move.
    repeat (2) @(posedge clk_i);
    #1;
    applyStimulus(8'h3C);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      for (int d = 0; d < 2; d++) begin
        checkOutput("reset_rd_en", {31'd0, rd_en[d]}, 32'd0);
        checkOutput("reset_sdata", {31'd0, sdata[d]}, 32'd1);
        checkOutput("reset_busy",  {31'd0, busy[d]},  32'd0);
        checkOutput("reset_svalid", {31'd0, svalid[d]}, 32'd0);
      end
    end
    rst_n_i = 1'b1;
    waitIdle(200);

    // Single word with a continuous tick: latency and one read pulse.
    @(posedge clk_i);
    #1;
    r0 = rd_cnt[0];
    applyStimulus(8'hA5);
    cycles = 0;
    while (!svalid[0] && cycles < 20) begin
      @(posedge clk_i);
      #1;
      cycles++;
    end
    checkOutput("first_bit_latency", cycles, 32'd3);
    waitIdle(200);
    checkOutput("single_rd_pulses", rd_cnt[0] - r0, 32'd1);

    // Back-to-back words: two read pulses and a two-cycle gap.
    @(posedge clk_i);
    #1;
    r0 = rd_cnt[0];
    applyStimulus(8'h01);
    applyStimulus(8'h80);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!slast[0] && n < 50);
    checkOutput("b2b_first_last_seen", {31'd0, slast[0]}, 32'd1);
    gap = 0;
    n   = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (!svalid[0]) gap++;
    end while (!svalid[0] && n < 50);
    checkOutput("b2b_gap_cycles", gap, 32'd2);
    waitIdle(200);
    checkOutput("b2b_rd_pulses", rd_cnt[0] - r0, 32'd2);

    // Slow tick: each bit held until the next strobe.
    tick_mode = 2;
    @(posedge clk_i);
    #1;
    applyStimulus(8'hF0);
    waitIdle(400);

    // Word whose parity bit (when enabled) is 1.
    tick_mode = 1;
    @(posedge clk_i);
    #1;
    applyStimulus(8'h07);
    waitIdle(200);

    // Reset in the middle of a frame.
    @(posedge clk_i);
    #1;
    applyStimulus(8'hFF);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!svalid[0] && n < 50);
    repeat (2) @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("async_reset_sdata",  {31'd0, sdata[d]},  32'd1);
      checkOutput("async_reset_svalid", {31'd0, svalid[d]}, 32'd0);
      checkOutput("async_reset_slast",  {31'd0, slast[d]},  32'd0);
      checkOutput("async_reset_busy",   {31'd0, busy[d]},   32'd0);
      checkOutput("async_reset_rd_en",  {31'd0, rd_en[d]},  32'd0);
    end
    exp0.delete();
    exp1.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    r0 = rd_cnt[0];
    repeat (10) begin
      @(posedge clk_i);
      #1;
      checkOutput("post_reset_idle", {30'd0, busy}, 32'd0);
    end
    checkOutput("post_reset_no_read", rd_cnt[0] - r0, 32'd0);

    // Randomized words, spacing and tick pattern.
    tick_mode = 3;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk_i);
      #1;
      applyStimulus(WIDTH'($urandom));
      if ($urandom_range(0, 3) == 0) applyStimulus(WIDTH'($urandom));
      repeat ($urandom_range(0, 30)) @(posedge clk_i);
    end
    waitIdle(20000);

    checkOutput("total_reads_lsb", rd_cnt[0], words_pushed);
    checkOutput("total_reads_msb", rd_cnt[1], words_pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
